// File: rtl/ntt_coeff_mem_ctrl.sv
// ntt_coeff_mem_ctrl: 256x12 dual-port coefficient RAM owner; AXI port while idle, engine ports during a transform
// Ports: clk/rst (async high); start_i/mode_i launch control; axi_bram_* AXI BRAM-like port;
//        eng_* butterfly engine launch, completion and two RAM ports; busy_o/done_o/irq_o/error_o status.
module ntt_coeff_mem_ctrl #(
  parameter int N  = 256,
  parameter int AW = 8,
  parameter int DW = 12,
  parameter int Q  = 3329
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic          mode_i,
  input  logic          axi_bram_en_i,
  input  logic          axi_bram_we_i,
  input  logic [AW-1:0] axi_bram_addr_i,
  input  logic [DW-1:0] axi_bram_din_i,
  output logic [DW-1:0] axi_bram_dout_o,
  output logic          eng_start_o,
  output logic          eng_mode_o,
  input  logic          eng_done_i,
  input  logic          eng_en_a_i,
  input  logic          eng_en_b_i,
  input  logic          eng_we_a_i,
  input  logic          eng_we_b_i,
  input  logic [AW-1:0] eng_addr_a_i,
  input  logic [AW-1:0] eng_addr_b_i,
  input  logic [DW-1:0] eng_din_a_i,
  input  logic [DW-1:0] eng_din_b_i,
  output logic [DW-1:0] eng_dout_a_o,
  output logic [DW-1:0] eng_dout_b_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          irq_o,
  output logic          error_o
);
  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, FINISH} state_t;
  state_t state_q;
  logic start_q, eng_start_q, eng_mode_q, busy_q, done_q, irq_q, error_q;
  logic [DW-1:0] axi_dout_q, dout_a_q, dout_b_q;
  logic [DW-1:0] mem [N];
  logic idle, run, start_edge, axi_wr, axi_rd, wr_a, wr_b;
  logic [DW-1:0] red_d;
  assign idle       = state_q == IDLE;
  assign run        = state_q == RUN;
  assign start_edge = start_i & ~start_q;
  assign axi_wr     = idle & axi_bram_en_i & axi_bram_we_i;
  assign axi_rd     = idle & axi_bram_en_i & ~axi_bram_we_i;
  assign wr_a       = run & eng_en_a_i & eng_we_a_i;
  assign wr_b       = run & eng_en_b_i & eng_we_b_i;
  // AXI inputs are at most 4095 < 2Q, so one conditional subtract fully reduces
  assign red_d      = axi_bram_din_i >= DW'(Q) ? axi_bram_din_i - DW'(Q) : axi_bram_din_i;
  // Port B is written first so a same-address port A write overrides it
  always_ff @(posedge clk) begin
    if (wr_b) mem[eng_addr_b_i] <= eng_din_b_i;
    if (wr_a) mem[eng_addr_a_i] <= eng_din_a_i;
    if (axi_wr) mem[axi_bram_addr_i] <= red_d;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      start_q     <= 1'b0;
      eng_start_q <= 1'b0;
      eng_mode_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      irq_q       <= 1'b0;
      error_q     <= 1'b0;
      axi_dout_q  <= '0;
      dout_a_q    <= '0;
      dout_b_q    <= '0;
    end else begin
      start_q     <= start_i;
      eng_start_q <= 1'b0;
      irq_q       <= 1'b0;
      case (state_q)
        IDLE: if (start_edge) begin
          state_q     <= LAUNCH;
          eng_start_q <= 1'b1;
          busy_q      <= 1'b1;
          eng_mode_q  <= mode_i;
          done_q      <= 1'b0;
          error_q     <= 1'b0;
        end
        LAUNCH: state_q <= RUN;
        RUN: if (eng_done_i) begin
          state_q <= FINISH;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          irq_q   <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
      // AXI traffic while the engine owns the RAM is flagged and answered with zero
      if (axi_bram_en_i && !idle) error_q <= 1'b1;
      if (axi_rd) axi_dout_q <= mem[axi_bram_addr_i];
      else if (axi_bram_en_i && !idle) axi_dout_q <= '0;
      if (run && eng_en_a_i && !eng_we_a_i) dout_a_q <= mem[eng_addr_a_i];
      if (run && eng_en_b_i && !eng_we_b_i) dout_b_q <= mem[eng_addr_b_i];
    end
  end
  assign axi_bram_dout_o = axi_dout_q;
  assign eng_start_o     = eng_start_q;
  assign eng_mode_o      = eng_mode_q;
  assign eng_dout_a_o    = dout_a_q;
  assign eng_dout_b_o    = dout_b_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign irq_o           = irq_q;
  assign error_o         = error_q;
endmodule

// File: tb/tb_ntt_coeff_mem_ctrl.sv
// tb_ntt_coeff_mem_ctrl: scoreboard bench with a behavioural model of the coefficient memory controller
module tb_ntt_coeff_mem_ctrl;
  localparam int Q = 3329;
  localparam int P_IDLE = 0, P_LAUNCH = 1, P_RUN = 2, P_FIN = 3;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, mode = 1'b0;
  logic a_en = 1'b0, a_we = 1'b0;
  logic [7:0] a_addr = '0;
  logic [11:0] a_din = '0;
  logic e_done = 1'b0, e_en_a = 1'b0, e_en_b = 1'b0, e_we_a = 1'b0, e_we_b = 1'b0;
  logic [7:0] e_addr_a = '0, e_addr_b = '0;
  logic [11:0] e_din_a = '0, e_din_b = '0;
  logic [11:0] axi_dout, dout_a, dout_b;
  logic eng_start, eng_mode, busy, done, irq, error;
  ntt_coeff_mem_ctrl dut (
    .clk(clk), .rst(rst), .start_i(start), .mode_i(mode),
    .axi_bram_en_i(a_en), .axi_bram_we_i(a_we), .axi_bram_addr_i(a_addr),
    .axi_bram_din_i(a_din), .axi_bram_dout_o(axi_dout),
    .eng_start_o(eng_start), .eng_mode_o(eng_mode), .eng_done_i(e_done),
    .eng_en_a_i(e_en_a), .eng_en_b_i(e_en_b), .eng_we_a_i(e_we_a), .eng_we_b_i(e_we_b),
    .eng_addr_a_i(e_addr_a), .eng_addr_b_i(e_addr_b),
    .eng_din_a_i(e_din_a), .eng_din_b_i(e_din_b),
    .eng_dout_a_o(dout_a), .eng_dout_b_o(dout_b),
    .busy_o(busy), .done_o(done), .irq_o(irq), .error_o(error)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {
    int due;
    int aout, da, db;
    bit st, md, bs, dn, iq, er;
  } exp_t;
  exp_t sbq[$];
  int checks = 0, errors = 0;
  int mem[256];
  int ph, m_ao, m_da, m_db;
  bit m_sp, m_md, m_dn, m_er;
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  function automatic int red(input int v);
    return v >= Q ? v - Q : v;
  endfunction
  task automatic mreset();
    ph = P_IDLE; m_sp = 0; m_md = 0; m_dn = 0; m_er = 0; m_ao = 0; m_da = 0; m_db = 0;
  endtask
  // Apply the currently driven inputs to the model, queue the expected post-edge outputs, advance one cycle
  task automatic tick();
    exp_t e;
    bit edge_seen;
    int nph;
    edge_seen = start && !m_sp;
    m_sp = start;
    if (a_en) m_ao = (ph != P_IDLE) ? 0 : (a_we ? m_ao : mem[a_addr]);
    if (ph == P_RUN) begin
      if (e_en_a && !e_we_a) m_da = mem[e_addr_a];
      if (e_en_b && !e_we_b) m_db = mem[e_addr_b];
    end
    if (ph == P_IDLE && a_en && a_we) mem[a_addr] = red(int'(a_din));
    if (ph == P_RUN) begin
      if (e_en_b && e_we_b) mem[e_addr_b] = int'(e_din_b);
      if (e_en_a && e_we_a) mem[e_addr_a] = int'(e_din_a);
    end
    if (ph != P_IDLE && a_en) m_er = 1;
    nph = ph;
    if (ph == P_IDLE && edge_seen) begin
      nph = P_LAUNCH; m_md = mode; m_dn = 0; m_er = 0;
    end else if (ph == P_LAUNCH) nph = P_RUN;
    else if (ph == P_RUN && e_done) begin
      nph = P_FIN; m_dn = 1;
    end else if (ph == P_FIN) nph = P_IDLE;
    ph = nph;
    e.due = cyc + 1; e.aout = m_ao; e.da = m_da; e.db = m_db;
    e.st = ph == P_LAUNCH; e.bs = ph == P_LAUNCH || ph == P_RUN; e.iq = ph == P_FIN;
    e.md = m_md; e.dn = m_dn; e.er = m_er;
    sbq.push_back(e);
    @(negedge clk);
    #1;
  endtask
  task automatic axi_op(input bit we, input int addr, input int din);
    a_en = 1; a_we = we; a_addr = 8'(addr); a_din = 12'(din);
    tick();
    a_en = 0; a_we = 0;
  endtask
  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_eng_start"}, int'(eng_start), 0);
    chk({tag, "_eng_mode"}, int'(eng_mode), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_irq"}, int'(irq), 0);
    chk({tag, "_error"}, int'(error), 0);
    chk({tag, "_axi_dout"}, int'(axi_dout), 0);
    chk({tag, "_dout_a"}, int'(dout_a), 0);
    chk({tag, "_dout_b"}, int'(dout_b), 0);
  endtask
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (sbq.size() > 0 && sbq[0].due <= cyc) begin
        e = sbq.pop_front();
        if (e.due < cyc) chk("late_entry", cyc, e.due);
        else begin
          chk("axi_dout", int'(axi_dout), e.aout);
          chk("dout_a", int'(dout_a), e.da);
          chk("dout_b", int'(dout_b), e.db);
          chk("eng_start", int'(eng_start), int'(e.st));
          chk("eng_mode", int'(eng_mode), int'(e.md));
          chk("busy", int'(busy), int'(e.bs));
          chk("done", int'(done), int'(e.dn));
          chk("irq", int'(irq), int'(e.iq));
          chk("error", int'(error), int'(e.er));
        end
      end
    end
  end
  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end
  initial begin : stim
    int prior;
    mreset();
    repeat (2) @(negedge clk);
    #1;
    chk_all_zero("reset");
    rst = 0;
    for (int i = 0; i < 256; i++) axi_op(1, i, $urandom_range(0, 4095));
    axi_op(1, 5, 100);
    axi_op(0, 5, 0);
    chk("t1_read", int'(axi_dout), 100);
    axi_op(1, 7, 4000);
    axi_op(0, 7, 0);
    chk("t2_reduce", int'(axi_dout), 671);
    axi_op(1, 7, 3329);
    axi_op(0, 7, 0);
    chk("t2_q", int'(axi_dout), 0);
    mode = 1; start = 1;
    tick();
    chk("t3_eng_start", int'(eng_start), 1);
    chk("t3_eng_mode", int'(eng_mode), 1);
    chk("t3_busy", int'(busy), 1);
    repeat (99) tick();
    start = 0; mode = 0;
    chk("t3_no_relaunch", int'(eng_start), 0);
    chk("t3_busy_run", int'(busy), 1);
    e_en_b = 1; e_we_b = 1; e_addr_b = 3; e_din_b = 12'd4095;
    tick();
    e_en_b = 0; e_we_b = 0; e_done = 1;
    tick();
    e_done = 0;
    chk("t4_done", int'(done), 1);
    chk("t4_irq", int'(irq), 1);
    chk("t4_busy", int'(busy), 0);
    tick();
    chk("t4_irq_pulse", int'(irq), 0);
    axi_op(0, 3, 0);
    chk("t4_unreduced", int'(axi_dout), 4095);
    prior = mem[0];
    start = 1;
    tick();
    start = 0;
    tick();
    axi_op(1, 0, 55);
    chk("t5_error", int'(error), 1);
    chk("t5_dout_zero", int'(axi_dout), 0);
    e_done = 1;
    tick();
    e_done = 0;
    tick();
    axi_op(0, 0, 0);
    chk("t5_write_dropped", int'(axi_dout), prior);
    chk("t5_error_sticky", int'(error), 1);
    start = 1;
    tick();
    chk("t5_error_cleared", int'(error), 0);
    start = 0;
    tick();
    e_done = 1;
    tick();
    e_done = 0;
    tick();
    mode = 1; start = 1;
    tick();
    start = 0;
    repeat (3) tick();
    chk("t6_pre_busy", int'(busy), 1);
    chk("t6_pre_mode", int'(eng_mode), 1);
    rst = 1;
    #1;
    chk_all_zero("t6_async");
    @(negedge clk);
    #1;
    chk_all_zero("t6_held");
    rst = 0; mode = 0;
    sbq.delete();
    mreset();
    axi_op(1, 9, 42);
    axi_op(0, 9, 0);
    chk("t6_axi_after", int'(axi_dout), 42);
    chk("t6_error_after", int'(error), 0);
    repeat (3000) begin
      if ($urandom_range(0, 15) == 0) start = !start;
      mode = 1'($urandom_range(0, 1));
      a_en = $urandom_range(0, 3) == 0;
      a_we = 1'($urandom_range(0, 1));
      a_addr = 8'($urandom_range(0, 15));
      a_din = 12'($urandom_range(0, 4095));
      e_done = $urandom_range(0, 11) == 0;
      e_en_a = 1'($urandom_range(0, 1));
      e_en_b = 1'($urandom_range(0, 1));
      e_we_a = 1'($urandom_range(0, 1));
      e_we_b = 1'($urandom_range(0, 1));
      e_addr_a = 8'($urandom_range(0, 15));
      e_addr_b = 8'($urandom_range(0, 15));
      e_din_a = 12'($urandom_range(0, 4095));
      e_din_b = 12'($urandom_range(0, 4095));
      tick();
    end
    start = 0; a_en = 0; e_en_a = 0; e_en_b = 0; e_done = 1;
    repeat (3) tick();
    e_done = 0;
    repeat (3) tick();
    for (int i = 0; i < 16; i++) axi_op(0, i, 0);
    for (int i = 0; i < 5 && sbq.size() > 0; i++) @(negedge clk);
    if (sbq.size() > 0) chk("drain", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
